// File: rtl/spi_burst_ram.sv
// Command-decoded RAM behind the SPI slave deserialiser: pointer set, write, and read with a ready/valid TX handshake.
// Define SPI_RAM_AUTOINC_EN to post-increment the pointers on WRITE and accepted READ (wrapping at MEM_DEPTH).
module spi_burst_ram #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 8,
  parameter int MEM_DEPTH = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W+1:0] din,
  input  logic              rx_valid,
  input  logic              tx_ready,
  input  logic              clr_err,
  output logic [DATA_W-1:0] dout,
  output logic              tx_valid,
  output logic              overrun,
  output logic              addr_err
);

  typedef enum logic [1:0] {
    OP_SET_WADDR = 2'b00,
    OP_WRITE     = 2'b01,
    OP_SET_RADDR = 2'b10,
    OP_READ      = 2'b11
  } op_e;

  localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(MEM_DEPTH);

  logic [DATA_W-1:0] mem [MEM_DEPTH];

  op_e               op;
  logic [DATA_W-1:0] payload;
  logic [ADDR_W-1:0] payload_addr;
  logic              in_range;

  logic [ADDR_W-1:0] w_addr, w_addr_d;
  logic [ADDR_W-1:0] r_addr, r_addr_d;
  logic [DATA_W-1:0] dout_d;
  logic              tx_valid_d, overrun_d, addr_err_d;
  logic              mem_we;

  assign op           = op_e'(din[DATA_W+1:DATA_W]);
  assign payload      = din[DATA_W-1:0];
  assign payload_addr = payload[ADDR_W-1:0];
  assign in_range     = ({1'b0, payload_addr} < DEPTH);

`ifdef SPI_RAM_AUTOINC_EN
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(MEM_DEPTH - 1);

  // Wrap at MEM_DEPTH rather than 2**ADDR_W so a partial-depth RAM never addresses a missing word.
  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
    return (a == LAST) ? '0 : a + ADDR_W'(1);
  endfunction
`else
  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
    return a;
  endfunction
`endif

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    w_addr_d   = w_addr;
    r_addr_d   = r_addr;
    dout_d     = dout;
    tx_valid_d = tx_valid;
    overrun_d  = overrun & ~clr_err;
    addr_err_d = addr_err & ~clr_err;
    mem_we     = 1'b0;

    if (tx_valid && tx_ready) tx_valid_d = 1'b0;

    // Error sets come after the clr_err defaults so a same-cycle error wins.
    if (rx_valid) begin
      case (op)
        OP_SET_WADDR: begin
          if (in_range) w_addr_d = payload_addr;
          else          addr_err_d = 1'b1;
        end
        OP_WRITE: begin
          mem_we   = 1'b1;
          w_addr_d = next_addr(w_addr);
        end
        OP_SET_RADDR: begin
          if (in_range) r_addr_d = payload_addr;
          else          addr_err_d = 1'b1;
        end
        OP_READ: begin
          if (!tx_valid || tx_ready) begin
            dout_d     = mem[r_addr];
            tx_valid_d = 1'b1;
            r_addr_d   = next_addr(r_addr);
          end else begin
            overrun_d = 1'b1;
          end
        end
      endcase
    end
  end

  // NOTE: the memory array has no reset; its contents survive rst and it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (mem_we) mem[w_addr] <= payload;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_addr   <= '0;
      r_addr   <= '0;
      dout     <= '0;
      tx_valid <= 1'b0;
      overrun  <= 1'b0;
      addr_err <= 1'b0;
    end else begin
      w_addr   <= w_addr_d;
      r_addr   <= r_addr_d;
      dout     <= dout_d;
      tx_valid <= tx_valid_d;
      overrun  <= overrun_d;
      addr_err <= addr_err_d;
    end
  end

endmodule
